// File: rtl/core_scheduler_if.sv
// Host/core handshake bundle for the batch core scheduler.
// The scheduler takes the slave side; the host and core array drive the master side.
interface core_scheduler_if #(
   parameter int NUM_CORES = 5,
   parameter int ROW_W     = 5
);
   logic                 start;
   logic [ROW_W-1:0]     num_rows;
   logic [NUM_CORES-1:0] core_ready;
   logic [NUM_CORES-1:0] core_finish;
   logic [NUM_CORES-1:0] core_start;
   logic [NUM_CORES-1:0] core_reset;
   logic [ROW_W-1:0]     row_base;
   logic [ROW_W-1:0]     batch_cnt;
   logic                 busy;
   logic                 done;

   modport master (
      output start, num_rows, core_ready, core_finish,
      input  core_start, core_reset, row_base, batch_cnt, busy, done
   );

   modport slave (
      input  start, num_rows, core_ready, core_finish,
      output core_start, core_reset, row_base, batch_cnt, busy, done
   );
endinterface

// File: rtl/core_scheduler.sv
// Splits num_rows into batches of up to NUM_CORES rows, launches cores (staggered on core_ready or all at once),
// waits for every active core_finish, then pulses core_reset; 2 cycles start-to-first-core_start, all outputs registered.
module core_scheduler #(
   parameter int NUM_CORES  = 5,
   parameter int ROW_W      = 5,
   parameter int STAGGER    = 1,
   parameter int RST_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   core_scheduler_if.slave bus
);
   localparam int CNT_W = $clog2(NUM_CORES + 1);
   localparam int RC_W  = $clog2(RST_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, RUN, RST, DONE} state_t;

   state_t               state;
   logic [ROW_W-1:0]     remaining;
   logic [CNT_W-1:0]     active;
   logic [NUM_CORES-1:0] active_mask;
   logic                 first_batch;
   logic [RC_W-1:0]      rst_cnt;

   logic [CNT_W-1:0]     load_active;
   logic [NUM_CORES-1:0] load_mask;
   logic                 launch_last;
   logic                 all_finished;

   // In LAUNCH, core_start itself is the one-hot launch pointer.
   always_comb begin
      load_active  = (32'(remaining) >= NUM_CORES) ? CNT_W'(NUM_CORES) : CNT_W'(remaining);
      load_mask    = '0;
      for (int k = 0; k < NUM_CORES; k++)
         load_mask[k] = (k < int'(load_active));
      launch_last  = ((bus.core_start << 1) & active_mask) == '0;
      all_finished = (bus.core_finish & active_mask) == active_mask;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         bus.core_start <= '0;
         bus.core_reset <= '0;
         bus.row_base   <= '0;
         bus.batch_cnt  <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         remaining      <= '0;
         active         <= '0;
         active_mask    <= '0;
         first_batch    <= 1'b0;
         rst_cnt        <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  bus.row_base  <= '0;
                  bus.batch_cnt <= '0;
                  if (bus.num_rows != '0) begin
                     remaining   <= bus.num_rows;
                     first_batch <= 1'b1;
                     bus.done    <= 1'b0;
                     bus.busy    <= 1'b1;
                     state       <= LOAD;
                  end else begin
                     bus.done <= 1'b1;
                     state    <= DONE;
                  end
               end
            end
            LOAD: begin
               active        <= load_active;
               active_mask   <= load_mask;
               remaining     <= remaining - ROW_W'(load_active);
               bus.batch_cnt <= bus.batch_cnt + 1'b1;
               if (!first_batch)
                  bus.row_base <= bus.row_base + ROW_W'(active);
               first_batch <= 1'b0;
               if (STAGGER != 0) begin
                  bus.core_start <= NUM_CORES'(1);
                  state          <= LAUNCH;
               end else begin
                  bus.core_start <= load_mask;
                  state          <= RUN;
               end
            end
            LAUNCH: begin
               if (|(bus.core_ready & bus.core_start)) begin
                  if (launch_last) begin
                     bus.core_start <= active_mask;
                     state          <= RUN;
                  end else begin
                     bus.core_start <= bus.core_start << 1;
                  end
               end
            end
            RUN: begin
               if (all_finished) begin
                  bus.core_start <= '0;
                  if (remaining != '0) begin
                     bus.core_reset <= active_mask;
                     rst_cnt        <= '0;
                     state          <= RST;
                  end else begin
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                     state    <= DONE;
                  end
               end
            end
            RST: begin
               if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                  bus.core_reset <= '0;
                  state          <= LOAD;
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/core_scheduler.md
CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 Parameter NUM_CORES, default 5, number of cores scheduled (1..16).
REQ-002 Parameter ROW_W, default 5, width of row count and row index.
REQ-003 Parameter STAGGER, default 1, 1 = cores launched one at a time, 0 = all active cores launched together.
REQ-004 Parameter RST_CYCLES, default 2, cycles core_reset is held between batches (>=1).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 start  in  1  request to process num_rows rows; sampled only in IDLE or DONE.
REQ-009 num_rows  in  ROW_W  total rows to process; latched on accepted start.
REQ-010 core_ready  in  NUM_CORES  core k has passed its shared-memory preload point.
REQ-011 core_finish  in  NUM_CORES  core k has completed its row (level).
REQ-012 core_start  out  NUM_CORES  run enable per core.
REQ-013 core_reset  out  NUM_CORES  per-core reset pulse between batches.
REQ-014 row_base  out  ROW_W  index of first row of current batch; core k works row row_base+k.
REQ-015 batch_cnt  out  ROW_W  batches launched since accepted start.
REQ-016 busy  out  1  high in every state except IDLE and DONE.
REQ-017 done  out  1  all rows complete; held until next accepted start or reset.

Function
REQ-018 States SHALL be IDLE, LOAD, LAUNCH, RUN, RST, DONE; all outputs registered.
REQ-019 IDLE/DONE, start=1, num_rows!=0: latch remaining=num_rows, row_base=0, batch_cnt=0, done=0, next LOAD.
REQ-020 IDLE/DONE, start=1, num_rows=0: done=1 next cycle, no core_start asserted.
REQ-021 start while busy SHALL be ignored.
REQ-022 LOAD (one cycle): active=min(remaining,NUM_CORES); active_mask=low active bits set; remaining-=active; batch_cnt+=1; launch_idx=0; next LAUNCH if STAGGER=1 else RUN.
REQ-023 row_base SHALL advance by previous batch's active in every LOAD except the first; width wraps mod 2^ROW_W.
REQ-024 LAUNCH: core_start = one-hot bit launch_idx only; core_ready of other cores ignored.
REQ-025 LAUNCH: core_ready[launch_idx]=1 with launch_idx<active-1 -> launch_idx+=1 next cycle; with launch_idx=active-1 -> RUN.
REQ-026 RUN: core_start=active_mask; next state when (core_finish & active_mask)==active_mask: RST if remaining>0, else DONE.
REQ-027 core_finish bits outside active_mask SHALL be ignored in every state.
REQ-028 RST: core_start=0, core_reset=active_mask for exactly RST_CYCLES cycles, then LOAD.
REQ-029 DONE: core_start=0, core_reset=0, done=1, busy=0.
REQ-030 Latency: accepted start to first core_start bit high = 2 cycles (IDLE->LOAD->LAUNCH/RUN).
REQ-031 Final batch with active<NUM_CORES SHALL never assert core_start or core_reset on cores >=active.
REQ-032 Same-cycle core_ready and core_finish on the launching core: ready handled, finish evaluated in RUN.

Reset
REQ-033 reset=1 at any edge, including mid-batch: state IDLE, core_start=0, core_reset=0, row_base=0, batch_cnt=0, busy=0, done=0; reset dominates start.

Verification
REQ-034 NUM_CORES=5, STAGGER=1, num_rows=15: cores started 0..4 one at a time on core_ready, 3 batches, row_base 0/5/10, core_reset=5'b11111 for 2 cycles twice, done=1, batch_cnt=3.
REQ-035 num_rows=7: batch 2 active=2, core_start=5'b00011 in RUN, cores 2..4 never started or reset, done=1.
REQ-036 STAGGER=0, num_rows=5: core_start=5'b11111 two cycles after start, done one cycle after all core_finish high.
REQ-037 num_rows=0 start: done=1 next cycle, busy never high, core_start stays 0.
REQ-038 reset during RUN of batch 2: next cycle all outputs 0, IDLE; later start num_rows=3 runs cleanly from row_base=0.
REQ-039 start pulsed during LAUNCH and RUN and stray core_finish on inactive cores: no state or output change.
